// File: rtl/controller_poller_m_pkg.sv
// Shared controller definitions: poll FSM encodings and button bit positions,
// also consumed by firmware-side tests.
package controller_poller_m_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_LOW    = 3'd2,
      ST_HIGH   = 3'd3,
      ST_COMMIT = 3'd4
   } poll_state_e;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam int CPU_DATA_W = 8;

endpackage

// File: rtl/controller_poller_m_timer.sv
// Phase timer: 8-bit down-counter reloaded to HALF_PERIOD-1, terminal count at zero.
module controller_timer_m #(
   parameter int HALF_PERIOD = 75
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic tc_o
);

   localparam logic [7:0] RELOAD = 8'(HALF_PERIOD - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = RELOAD;
      else if (cnt_q != 8'd0)
         cnt_d = cnt_q - 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == 8'd0);

endmodule

// File: rtl/controller_poller_m.sv
// Polls two serial game controllers once per start pulse and holds the
// decoded button bytes (1 = pressed) for CPU reads.
module controller_poller_m
   import controller_poller_m_pkg::*;
#(
   parameter int HALF_PERIOD = 75,
   parameter int NUM_BITS    = 8
) (
   input  logic       clk_12_5875,
   input  logic       rst,
   input  logic       start,
   input  logic       ctrl_data_1,
   input  logic       ctrl_data_2,
   output logic       ctrl_latch,
   output logic       ctrl_clk,
   input  logic       SELECT_controller,
   input  logic       address_bit,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       valid
);

   localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

   poll_state_e          state_q;
   logic                 latch_half_q;
   logic [IDX_W-1:0]     idx_q;
   logic [1:0]           sync1_q, sync2_q;
   logic [NUM_BITS-1:0]  sr1_q, sr2_q;
   logic [CPU_DATA_W-1:0] held1_q, held2_q;
   logic                 ctrl_latch_q, ctrl_clk_q, busy_q, valid_q;
   logic                 tim_load, tim_tc;

   always_ff @(posedge clk_12_5875) begin
      if (rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= {sync1_q[0], ctrl_data_1};
         sync2_q <= {sync2_q[0], ctrl_data_2};
      end
   end

   // The timer restarts on poll start and at every terminal count of a timed
   // phase; LATCH spans two such periods so the counter stays within 8 bits.
   assign tim_load = ((state_q == ST_IDLE) && start) ||
                     (((state_q == ST_LATCH) || (state_q == ST_LOW) ||
                       (state_q == ST_HIGH)) && tim_tc);

   controller_timer_m #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_timer (
      .clk_i  (clk_12_5875),
      .rst_i  (rst),
      .load_i (tim_load),
      .tc_o   (tim_tc)
   );

   always_ff @(posedge clk_12_5875) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         latch_half_q <= 1'b0;
         idx_q        <= '0;
         sr1_q        <= '0;
         sr2_q        <= '0;
         held1_q      <= '0;
         held2_q      <= '0;
         ctrl_latch_q <= 1'b0;
         ctrl_clk_q   <= 1'b1;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q      <= ST_LATCH;
                  latch_half_q <= 1'b0;
                  ctrl_latch_q <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            ST_LATCH: begin
               if (tim_tc) begin
                  if (latch_half_q) begin
                     state_q      <= ST_LOW;
                     idx_q        <= '0;
                     ctrl_latch_q <= 1'b0;
                     ctrl_clk_q   <= 1'b0;
                  end else begin
                     latch_half_q <= 1'b1;
                  end
               end
            end
            ST_LOW: begin
               if (tim_tc) begin
                  // Shift in from the top so the first bit read lands in bit 0.
                  sr1_q      <= {~sync1_q[1], sr1_q[NUM_BITS-1:1]};
                  sr2_q      <= {~sync2_q[1], sr2_q[NUM_BITS-1:1]};
                  ctrl_clk_q <= 1'b1;
                  state_q    <= (idx_q == LAST_IDX) ? ST_COMMIT : ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (tim_tc) begin
                  idx_q      <= idx_q + IDX_W'(1);
                  ctrl_clk_q <= 1'b0;
                  state_q    <= ST_LOW;
               end
            end
            ST_COMMIT: begin
               held1_q <= CPU_DATA_W'(sr1_q);
               held2_q <= CPU_DATA_W'(sr2_q);
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q      <= ST_IDLE;
               ctrl_latch_q <= 1'b0;
               ctrl_clk_q   <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      data_out = 8'h00;
      if (SELECT_controller)
         data_out = address_bit ? held2_q : held1_q;
   end

   assign ctrl_latch = ctrl_latch_q;
   assign ctrl_clk   = ctrl_clk_q;
   assign busy       = busy_q;
   assign valid      = valid_q;

endmodule

// File: tb/tb_controller_poller_m.sv
// Directed bench for controller_poller_m with HALF_PERIOD=4, NUM_BITS=8.
module tb_controller_poller_m;
   import controller_poller_m_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start, ctrl_data_1, ctrl_data_2, SELECT_controller, address_bit;
   logic       ctrl_latch, ctrl_clk, busy, valid;
   logic [7:0] data_out;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] c1_line  = 8'hFF;
   logic [7:0] c2_line  = 8'hFF;

   typedef struct {
      logic [7:0] c1_line;
      logic [7:0] c2_line;
      logic [7:0] exp1;
      logic [7:0] exp2;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   controller_poller_m #(
      .HALF_PERIOD (4),
      .NUM_BITS    (8)
   ) dut (
      .clk_12_5875       (clk),
      .rst               (rst),
      .start             (start),
      .ctrl_data_1       (ctrl_data_1),
      .ctrl_data_2       (ctrl_data_2),
      .ctrl_latch        (ctrl_latch),
      .ctrl_clk          (ctrl_clk),
      .SELECT_controller (SELECT_controller),
      .address_bit       (address_bit),
      .data_out          (data_out),
      .busy              (busy),
      .valid             (valid)
   );

   // Controller model: latch loads bit 0, each ctrl_clk rise advances one bit.
   initial begin
      int   m_idx;
      logic m_prev_clk;
      m_idx       = 8;
      m_prev_clk  = 1'b1;
      ctrl_data_1 = 1'b1;
      ctrl_data_2 = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ctrl_latch === 1'b1)
            m_idx = 0;
         else if (ctrl_clk === 1'b1 && m_prev_clk === 1'b0 && m_idx < 8)
            m_idx++;
         m_prev_clk  = ctrl_clk;
         ctrl_data_1 = (m_idx < 8) ? c1_line[m_idx] : 1'b1;
         ctrl_data_2 = (m_idx < 8) ? c2_line[m_idx] : 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic read_cpu(input logic sel, input logic addr, output logic [7:0] v);
      SELECT_controller = sel;
      address_bit       = addr;
      #1;
      v = data_out;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic finish_poll(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   function automatic logic exp_clk(input int k);
      if (k < 8 || k >= 68)
         return 1'b1;
      return (((k - 8) / 4) % 2) != 0;
   endfunction

   initial begin
      logic [7:0] rd;
      logic       lat_s[70];
      logic       clk_s[70];
      int         n, cnt_lat, cnt_busy;

      vecs[0] = '{8'hF6, 8'hFF, 8'h09, 8'h00};
      vecs[1] = '{8'h5A, 8'hA5, 8'hA5, 8'h5A};
      vecs[2] = '{8'h7E, 8'hFE, 8'h81, 8'h01};
      vecs[3] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
      vecs[4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};

      rst = 1'b1; start = 1'b0; SELECT_controller = 1'b1; address_bit = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_latch", ctrl_latch, 0);
      check("rst_clk", ctrl_clk, 1);
      read_cpu(1, 0, rd); check("rst_data1", rd, 8'h00);
      read_cpu(1, 1, rd); check("rst_data2", rd, 8'h00);
      rst = 1'b0;
      repeat (6) tick();
      check("no_poll_after_rst", busy, 0);

      // Waveform of one full poll, sampled once per cycle from LATCH entry.
      pulse_start();
      for (int k = 0; k < 70; k++) begin
         lat_s[k] = ctrl_latch;
         clk_s[k] = ctrl_clk;
         if (k == 68) check("wave_busy_commit", busy, 1);
         if (k == 69) check("wave_busy_done", busy, 0);
         tick();
      end
      for (int k = 0; k < 70; k++) begin
         check($sformatf("wave_latch[%0d]", k), lat_s[k], (k < 8) ? 1 : 0);
         check($sformatf("wave_clk[%0d]", k), clk_s[k], exp_clk(k));
      end
      check("wave_valid", valid, 1);

      for (int i = 0; i < 5; i++) begin
         c1_line = vecs[i].c1_line;
         c2_line = vecs[i].c2_line;
         tick();
         pulse_start();
         finish_poll(n);
         check($sformatf("v%0d_busy_len", i), n, 69);
         check($sformatf("v%0d_valid", i), valid, 1);
         read_cpu(1, 0, rd); check($sformatf("v%0d_held1", i), rd, vecs[i].exp1);
         read_cpu(1, 1, rd); check($sformatf("v%0d_held2", i), rd, vecs[i].exp2);
         tick();
      end
      check("btn_map_a_start", 8'((1 << BTN_A) | (1 << BTN_START)), vecs[0].exp1);

      // CPU read across the COMMIT cycle sees the old byte, then the new one.
      c1_line = 8'hFF; c2_line = 8'h0F;
      SELECT_controller = 1'b1; address_bit = 1'b1;
      tick();
      pulse_start();
      repeat (68) tick();
      check("commit_busy", busy, 1);
      check("commit_old", data_out, 8'h00);
      tick();
      check("commit_new", data_out, 8'hF0);
      check("commit_idle", busy, 0);

      // start re-pulsed mid-poll and in COMMIT must be dropped.
      c1_line = 8'hFF; c2_line = 8'hFF;
      tick();
      pulse_start();
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         if (n == 10 || n == 68) start = 1'b1;
         tick();
         start = 1'b0;
         n++;
      end
      check("repulse_busy_len", n, 69);
      cnt_lat = 0; cnt_busy = 0;
      repeat (20) begin
         tick();
         if (ctrl_latch === 1'b1) cnt_lat++;
         if (busy === 1'b1) cnt_busy++;
      end
      check("repulse_no_latch", cnt_lat, 0);
      check("repulse_no_busy", cnt_busy, 0);

      c1_line = 8'h00; c2_line = 8'h00;
      tick();
      pulse_start();
      finish_poll(n);
      check("ff_busy_len", n, 69);
      read_cpu(1, 0, rd); check("ff_held1", rd, 8'hFF);
      read_cpu(1, 1, rd); check("ff_held2", rd, 8'hFF);
      read_cpu(0, 0, rd); check("nosel_addr0", rd, 8'h00);
      read_cpu(0, 1, rd); check("nosel_addr1", rd, 8'h00);

      // Reset landing in the middle of a poll.
      tick();
      pulse_start();
      repeat (30) tick();
      check("midpoll_busy", busy, 1);
      rst = 1'b1;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_valid", valid, 0);
      check("midrst_latch", ctrl_latch, 0);
      check("midrst_clk", ctrl_clk, 1);
      read_cpu(1, 0, rd); check("midrst_data1", rd, 8'h00);
      read_cpu(1, 1, rd); check("midrst_data2", rd, 8'h00);
      rst = 1'b0;
      cnt_busy = 0;
      repeat (10) begin
         tick();
         if (busy === 1'b1 || ctrl_latch === 1'b1) cnt_busy++;
      end
      check("midrst_stays_idle", cnt_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
